// File: rtl/cmp_arbiter_if.sv
// Request/response channel for one requester of the shared branch comparator.
// The requester drives the master side and the arbiter the slave side.
interface cmp_arbiter_if #(
  parameter int unsigned TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      a;
  logic [31:0]      b;
  logic [2:0]       ctrl;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             c;
  logic             err;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, a, b, ctrl, req_tag, rsp_ready,
    input  req_ready, rsp_valid, c, err, rsp_tag
  );

  modport slave (
    input  req_valid, a, b, ctrl, req_tag, rsp_ready,
    output req_ready, rsp_valid, c, err, rsp_tag
  );
endinterface

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one 32-bit branch-condition comparator between two
// requesters; results land in per-requester response slots held until consumed.
module cmp_arbiter #(
  parameter int unsigned TAG_W      = 4,
  parameter bit          PRIO_RESET = 1'b0
) (
  input  logic         clk,
  input  logic         rstn,
  cmp_arbiter_if.slave ch0,
  cmp_arbiter_if.slave ch1,
  output logic [15:0]  grant_cnt0,
  output logic [15:0]  grant_cnt1
);

  logic [1:0]       req_valid;
  logic [1:0]       rsp_ready;
  logic [1:0]       slot_free;
  logic [1:0]       elig;
  logic [1:0]       grant;
  logic [31:0]      op_a   [2];
  logic [31:0]      op_b   [2];
  logic [2:0]       op_ctrl[2];
  logic [TAG_W-1:0] op_tag [2];

  // Index of the requester granted most recently; the other one wins a tie.
  logic last_q, last_d;

  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [1:0]       rsp_c_q, rsp_c_d;
  logic [1:0]       rsp_err_q, rsp_err_d;
  logic [TAG_W-1:0] rsp_tag_q[2];
  logic [TAG_W-1:0] rsp_tag_d[2];
  logic [15:0]      cnt_q[2];
  logic [15:0]      cnt_d[2];

  logic [31:0]      cmp_a, cmp_b;
  logic [2:0]       cmp_ctrl;
  logic [TAG_W-1:0] cmp_tag;
  logic             cmp_c, cmp_err;
  logic             lt_s, lt_u;

  assign req_valid  = {ch1.req_valid, ch0.req_valid};
  assign rsp_ready  = {ch1.rsp_ready, ch0.rsp_ready};
  assign op_a[0]    = ch0.a;
  assign op_a[1]    = ch1.a;
  assign op_b[0]    = ch0.b;
  assign op_b[1]    = ch1.b;
  assign op_ctrl[0] = ch0.ctrl;
  assign op_ctrl[1] = ch1.ctrl;
  assign op_tag[0]  = ch0.req_tag;
  assign op_tag[1]  = ch1.req_tag;

  // Arbitration; a full slot that drains this cycle counts as free.
  always_comb begin
    slot_free = ~rsp_valid_q | rsp_ready;
    elig      = req_valid & slot_free & {2{rstn}};
    grant     = 2'b00;
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    last_d = last_q;
    if (grant[1]) begin
      last_d = 1'b1;
    end else if (grant[0]) begin
      last_d = 1'b0;
    end
  end

  // Shared comparator on the granted operands.
  always_comb begin
    cmp_a    = grant[1] ? op_a[1]    : op_a[0];
    cmp_b    = grant[1] ? op_b[1]    : op_b[0];
    cmp_ctrl = grant[1] ? op_ctrl[1] : op_ctrl[0];
    cmp_tag  = grant[1] ? op_tag[1]  : op_tag[0];
    lt_s     = $signed(cmp_a) < $signed(cmp_b);
    lt_u     = cmp_a < cmp_b;
    cmp_c    = 1'b0;
    cmp_err  = 1'b0;
    case (cmp_ctrl)
      3'b001:  cmp_c = (cmp_a == cmp_b);
      3'b010:  cmp_c = (cmp_a != cmp_b);
      3'b011:  cmp_c = lt_s;
      3'b100:  cmp_c = lt_u;
      3'b101:  cmp_c = ~lt_s;
      3'b110:  cmp_c = ~lt_u;
      default: cmp_err = 1'b1;
    endcase
  end

  // Response slots and grant counters.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rsp_valid_d[i] = rsp_valid_q[i];
      rsp_c_d[i]     = rsp_c_q[i];
      rsp_err_d[i]   = rsp_err_q[i];
      rsp_tag_d[i]   = rsp_tag_q[i];
      cnt_d[i]       = cnt_q[i];
      if (grant[i]) begin
        rsp_valid_d[i] = 1'b1;
        rsp_c_d[i]     = cmp_c;
        rsp_err_d[i]   = cmp_err;
        rsp_tag_d[i]   = cmp_tag;
        if (cnt_q[i] != 16'hFFFF) begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end else if (rsp_ready[i]) begin
        // Payload fields keep their last value after a plain consume.
        rsp_valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q      <= ~PRIO_RESET;
      rsp_valid_q <= '0;
      rsp_c_q     <= '0;
      rsp_err_q   <= '0;
      rsp_tag_q   <= '{default: '0};
      cnt_q       <= '{default: '0};
    end else begin
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_c_q     <= rsp_c_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tag_q   <= rsp_tag_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ch0.req_ready = grant[0];
  assign ch1.req_ready = grant[1];
  assign ch0.rsp_valid = rsp_valid_q[0];
  assign ch1.rsp_valid = rsp_valid_q[1];
  assign ch0.c         = rsp_c_q[0];
  assign ch1.c         = rsp_c_q[1];
  assign ch0.err       = rsp_err_q[0];
  assign ch1.err       = rsp_err_q[1];
  assign ch0.rsp_tag   = rsp_tag_q[0];
  assign ch1.rsp_tag   = rsp_tag_q[1];
  assign grant_cnt0    = cnt_q[0];
  assign grant_cnt1    = cnt_q[1];

  a_one_grant: assert property (@(posedge clk) disable iff (!rstn) !(grant[0] && grant[1]));

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter: stimulus pushes hand-computed responses into
// per-requester queues; a negedge monitor pops them as responses are consumed.
module tb_cmp_arbiter;
  localparam logic [2:0] EQ = 3'b001, NE = 3'b010, LT = 3'b011, LTU = 3'b100;
  localparam logic [2:0] GE = 3'b101, GEU = 3'b110;

  typedef struct packed {
    logic       c;
    logic       err;
    logic [3:0] tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [15:0] grant_cnt0, grant_cnt1;
  int          n_tests = 0;
  int          n_fail = 0;
  bit          sb_on = 1'b1;
  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        exp0, exp1;

  cmp_arbiter_if #(.TAG_W(4)) p0 ();
  cmp_arbiter_if #(.TAG_W(4)) p1 ();

  cmp_arbiter #(.TAG_W(4), .PRIO_RESET(1'b0)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .ch0        (p0),
    .ch1        (p1),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running sim, required $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic pop_chk(input int ch, input logic c, input logic e, input logic [3:0] tag);
    exp_t x;
    if ((ch == 0 && q0.size() == 0) || (ch == 1 && q1.size() == 0)) begin
      n_tests++;
      n_fail++;
      $display("FAIL rsp%0d unexpected: got response tag %0h required none", ch, tag);
      return;
    end
    x = (ch == 0) ? q0.pop_front() : q1.pop_front();
    chk($sformatf("rsp%0d c tag%0h", ch, x.tag), 32'(c), 32'(x.c));
    chk($sformatf("rsp%0d err tag%0h", ch, x.tag), 32'(e), 32'(x.err));
    chk($sformatf("rsp%0d tag", ch), 32'(tag), 32'(x.tag));
  endtask

  // Monitor: a response is consumed when valid and ready meet at the next edge.
  always @(negedge clk) begin
    if (sb_on && rstn) begin
      if (p0.rsp_valid && p0.rsp_ready) pop_chk(0, p0.c, p0.err, p0.rsp_tag);
      if (p1.rsp_valid && p1.rsp_ready) pop_chk(1, p1.c, p1.err, p1.rsp_tag);
    end
  end

  task automatic drv0(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] ctrl, input logic [3:0] tag,
                      input logic ec, input logic ee);
    p0.req_valid = v;
    p0.a = a;
    p0.b = b;
    p0.ctrl = ctrl;
    p0.req_tag = tag;
    exp0 = '{c: ec, err: ee, tag: tag};
  endtask

  task automatic drv1(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] ctrl, input logic [3:0] tag,
                      input logic ec, input logic ee);
    p1.req_valid = v;
    p1.a = a;
    p1.b = b;
    p1.ctrl = ctrl;
    p1.req_tag = tag;
    exp1 = '{c: ec, err: ee, tag: tag};
  endtask

  // One cycle: set rsp_ready, check the expected grants, record expected responses.
  task automatic step(input logic rr0, input logic rr1, input logic g0, input logic g1,
                      input string name);
    p0.rsp_ready = rr0;
    p1.rsp_ready = rr1;
    @(negedge clk);
    chk({name, " req0_ready"}, 32'(p0.req_ready), 32'(g0));
    chk({name, " req1_ready"}, 32'(p1.req_ready), 32'(g1));
    if (g0) q0.push_back(exp0);
    if (g1) q1.push_back(exp1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    drv0(1'b1, 32'd0, 32'd0, EQ, 4'd0, 1'b1, 1'b0);
    drv1(1'b0, 32'd0, 32'd0, EQ, 4'd0, 1'b1, 1'b0);
    p0.rsp_ready = 1'b1;
    p1.rsp_ready = 1'b1;
    #1 rstn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    // Reset state, with req0 valid held during reset
    chk("reset req0_ready", 32'(p0.req_ready), 32'd0);
    chk("reset rsp0_valid", 32'(p0.rsp_valid), 32'd0);
    chk("reset rsp1_valid", 32'(p1.rsp_valid), 32'd0);
    chk("reset rsp0 fields", {p0.c, p0.err, p0.rsp_tag}, 32'd0);
    chk("reset cnt", {grant_cnt1, grant_cnt0}, 32'd0);
    rstn = 1'b1;
    drv0(1'b0, 32'd0, 32'd0, EQ, 4'd0, 1'b1, 1'b0);

    // Single request
    drv0(1'b1, 32'd5, 32'd5, EQ, 4'd3, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, "single");
    drv0(1'b0, 32'd5, 32'd5, EQ, 4'd3, 1'b1, 1'b0);
    chk("single rsp0_valid", 32'(p0.rsp_valid), 32'd1);
    chk("single rsp0 c/err/tag", {p0.c, p0.err, p0.rsp_tag}, 32'b10_0011);
    chk("single cnt0", 32'(grant_cnt0), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, "drain");
    chk("consumed rsp0_valid", 32'(p0.rsp_valid), 32'd0);
    chk("consumed fields kept", {p0.c, p0.err, p0.rsp_tag}, 32'b10_0011);

    // Signed vs unsigned, back-to-back on requester 1
    drv1(1'b1, 32'hFFFF_FFFF, 32'd1, LT, 4'd1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, "lt");
    drv1(1'b1, 32'hFFFF_FFFF, 32'd1, LTU, 4'd2, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, "ltu");
    drv1(1'b1, 32'hFFFF_FFFF, 32'd1, GE, 4'd3, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, "ge");
    drv1(1'b1, 32'hFFFF_FFFF, 32'd1, GEU, 4'd4, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, "geu");
    drv1(1'b0, 32'd0, 32'd0, EQ, 4'd0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, "drain");

    // Contention: strict alternation starting with requester 0
    drv0(1'b1, 32'd10, 32'd20, LT, 4'd5, 1'b1, 1'b0);
    drv1(1'b1, 32'd7, 32'd7, NE, 4'd6, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, "contend");
      step(1'b1, 1'b1, 1'b0, 1'b1, "contend");
    end
    drv0(1'b0, 32'd0, 32'd0, EQ, 4'd0, 1'b1, 1'b0);
    drv1(1'b0, 32'd0, 32'd0, EQ, 4'd0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, "drain");
    chk("contend cnt0", 32'(grant_cnt0), 32'd4);
    chk("contend cnt1", 32'(grant_cnt1), 32'd7);

    // Backpressure on slot 0, then consume and refill in one cycle
    drv0(1'b1, 32'd3, 32'd9, GEU, 4'd7, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, "bp load");
    drv0(1'b1, 32'd9, 32'd3, GEU, 4'd8, 1'b1, 1'b0);
    drv1(1'b1, 32'd1, 32'd2, GE, 4'd9, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, "bp full");
    chk("bp hold", {p0.rsp_valid, p0.c, p0.err, p0.rsp_tag}, 32'b100_0111);
    drv1(1'b0, 32'd0, 32'd0, EQ, 4'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, "bp full");
    chk("bp hold2", {p0.rsp_valid, p0.c, p0.err, p0.rsp_tag}, 32'b100_0111);
    step(1'b1, 1'b1, 1'b1, 1'b0, "bp refill");
    chk("bp refilled", {p0.rsp_valid, p0.c, p0.err, p0.rsp_tag}, 32'b110_1000);
    drv0(1'b0, 32'd0, 32'd0, EQ, 4'd0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, "drain");

    // Illegal compare codes
    drv1(1'b1, 32'd0, 32'd0, 3'b111, 4'hA, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, "ctrl111");
    chk("ctrl111 c/err", {p1.c, p1.err}, 32'b01);
    drv1(1'b0, 32'd0, 32'd0, EQ, 4'd0, 1'b1, 1'b0);
    drv0(1'b1, 32'd1, 32'd1, 3'b000, 4'hB, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, "ctrl000");
    drv0(1'b0, 32'd0, 32'd0, EQ, 4'd0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, "drain");
    chk("cnt0 before reset", 32'(grant_cnt0), 32'd7);
    chk("cnt1 before reset", 32'(grant_cnt1), 32'd9);

    // Mid-operation asynchronous reset
    drv1(1'b1, 32'd5, 32'd6, LTU, 4'hC, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, "pre-reset");
    drv1(1'b0, 32'd0, 32'd0, EQ, 4'd0, 1'b1, 1'b0);
    drv0(1'b1, 32'd2, 32'd2, EQ, 4'hD, 1'b1, 1'b0);
    chk("pre-reset rsp1_valid", 32'(p1.rsp_valid), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("async reset rsp1", {p1.rsp_valid, p1.c, p1.err, p1.rsp_tag}, 32'd0);
    chk("async reset cnt", {grant_cnt1, grant_cnt0}, 32'd0);
    chk("async reset req0_ready", 32'(p0.req_ready), 32'd0);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1 rstn = 1'b1;
    drv1(1'b1, 32'd5, 32'd6, LTU, 4'hC, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, "post-reset tie");
    step(1'b1, 1'b1, 1'b0, 1'b1, "post-reset alt");
    drv0(1'b0, 32'd0, 32'd0, EQ, 4'd0, 1'b1, 1'b0);
    drv1(1'b0, 32'd0, 32'd0, EQ, 4'd0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, "drain");
    chk("post-reset cnt", {grant_cnt1, grant_cnt0}, {16'd1, 16'd1});

    // Saturation: requester 1 granted every cycle up to 16'hFFFE, then 3 more
    sb_on = 1'b0;
    drv1(1'b1, 32'd0, 32'd0, EQ, 4'd0, 1'b1, 1'b0);
    repeat (65533) @(posedge clk);
    #1;
    chk("cnt1 at FFFE", 32'(grant_cnt1), 32'hFFFE);
    repeat (3) @(posedge clk);
    #1;
    chk("cnt1 saturated", 32'(grant_cnt1), 32'hFFFF);
    repeat (2) @(posedge clk);
    #1;
    chk("cnt1 stays saturated", 32'(grant_cnt1), 32'hFFFF);
    chk("cnt0 untouched", 32'(grant_cnt0), 32'd1);
    drv1(1'b0, 32'd0, 32'd0, EQ, 4'd0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    sb_on = 1'b1;

    chk("q0 drained", 32'(q0.size()), 32'd0);
    chk("q1 drained", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cmp_arbiter.md
# cmp_arbiter

Shares one 32-bit branch-condition comparator between two requesters, e.g. the branch unit and a trap/CSR check path, in the CPU core. It arbitrates round-robin with a valid/ready handshake and evaluates the selected compare. The result is registered into a per-requester response slot, one cycle after acceptance, and held until the requester consumes it. It also keeps saturating per-requester grant counters for performance monitoring.

## Interface
Parameters:
- TAG_W, 4, width of the opaque tag carried from request to response
- PRIO_RESET, 0, requester that wins the first tie after reset (0 or 1)

Ports (index i = 0, 1; one set per requester):
- clk  in  1  clock; all state changes on its rising edge
- rstn  in  1  asynchronous, active-low reset
- req{i}_valid  in  1  request present
- req{i}_ready  out  1  request accepted this cycle (grant)
- req{i}_a  in  32  operand a
- req{i}_b  in  32  operand b
- req{i}_ctrl  in  3  compare code: 001 EQ, 010 NE, 011 LT (signed), 100 LTU, 101 GE (signed), 110 GEU
- req{i}_tag  in  TAG_W  tag, returned unchanged
- rsp{i}_valid  out  1  response slot full
- rsp{i}_ready  in  1  requester consumes the response
- rsp{i}_c  out  1  compare result
- rsp{i}_err  out  1  ctrl was 000 or 111
- rsp{i}_tag  out  TAG_W  tag of the answered request
- grant_cnt{i}  out  16  saturating count of accepted requests

## Operation
- Eligibility: requester i is eligible when req{i}_valid=1 and its slot is free. A slot is free when rsp{i}_valid=0, or when rsp{i}_valid & rsp{i}_ready holds in the same cycle.
- Arbitration:
  - Only one eligible requester: it is granted.
  - Both eligible: grant the one not granted most recently, using a 1-bit last-grant pointer.
  - Neither eligible: no grant.
  - At most one req{i}_ready is high per cycle.
- Pointer update: the pointer updates only on a grant. After reset its value makes PRIO_RESET win the first tie.
- Compare, done on the granted operands:
  - EQ: a==b. NE: a!=b.
  - LT/GE: two's-complement signed; GE = !LT.
  - LTU/GEU: unsigned; GEU = !LTU.
  - ctrl 000 or 111: c=0 and err=1. Otherwise err=0.
- Accepted request: loads c, err and tag into the granted slot at the next edge and sets rsp{i}_valid.
- Holding: the slot holds all fields stable while rsp{i}_valid=1 and rsp{i}_ready=0.
- Consume without refill: rsp{i}_valid clears at the edge. rsp{i}_c, rsp{i}_err and rsp{i}_tag keep their last value.
- Consume and refill in the same cycle: the new response replaces the old one and rsp{i}_valid stays 1.
- rsp{i}_ready while rsp{i}_valid=0 is ignored.
- Counters: grant_cnt{i} increments on each grant to i and saturates at 16'hFFFF.
- Reset (asynchronous, any time including mid-transaction):
  - rsp{i}_valid, rsp{i}_c, rsp{i}_err and rsp{i}_tag go to 0. Pending responses are discarded.
  - grant_cnt{i} goes to 0 and the pointer returns to its reset value.
  - req{i}_ready evaluates low while rstn=0.

## Timing
- req{i}_ready is combinational from the req{0,1}_valid, rsp{i}_valid and rsp{i}_ready inputs and the registered state. It is not registered.
- Latency: a request accepted in cycle N has rsp{i}_valid=1 in cycle N+1.
- Throughput:
  - One accept per cycle across both requesters.
  - One requester alone can be accepted every cycle when it drains its slot each cycle.
  - With both requesters continuously eligible, grants strictly alternate.
- Slot full and not draining: req{i}_ready=0 regardless of arbitration. Any grant goes to the other requester.
- Requesters must hold a, b, ctrl and tag stable while valid=1 and ready=0. The block does not check this.
- grant_cnt{i} updates at the same edge that loads the slot.

## Test plan
- Reset then single request: req0 with a=5, b=5, ctrl=001 and tag=3, rsp0_ready=1 → req0_ready=1 in that cycle; next cycle rsp0_valid=1, c=1, err=0, tag=3; grant_cnt0=1.
- Signed vs unsigned: req1 with a=32'hFFFFFFFF and b=1, sent with ctrl=011, then 100, then 101, then 110 → c=1, 0, 0, 1.
- Contention: both requesters valid every cycle with PRIO_RESET=0 and both rsp_ready=1 for 6 cycles → grants 0,1,0,1,0,1; grant_cnt0=3, grant_cnt1=3.
- Backpressure: rsp0_ready=0 after one response while req0 stays valid → req0_ready=0 and the slot holds its value; req1 is still granted. Then raise rsp0_ready → in that same cycle the slot is consumed and req0 is re-accepted, so rsp0_valid stays 1 with the new result.
- Illegal ctrl: ctrl=111 with a=b=0 → c=0, err=1. Saturation: a forced/preloaded count of 16'hFFFE plus 3 grants → grant_cnt=16'hFFFF.
- Mid-operation reset: drop rstn asynchronously while rsp1_valid=1 and req0 is valid → all rsp outputs and counters read 0 immediately; after release, the first tie goes to PRIO_RESET.
